// File: rtl/data_ram_arb.sv
// -----------------------------------------------------------------------------
// data_ram_arb
// Two-host arbiter in front of a single-port data RAM with 1-cycle read latency.
// Host 0 is the core LSU, host 1 the debug/DMA port. At most one request is
// granted per cycle (round-robin on contention) and forwarded to the RAM. The
// response is routed back to the host that was granted one cycle earlier.
// Addresses outside the RAM window are granted but never forwarded; they are
// answered locally with err=1 and rdata=0.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   h_req_i/h_we_i             per-host request / write enable
//   h_be_i/h_addr_i/h_wdata_i  per-host byte enables, byte address, write data
//   h_gnt_o                    per-host grant, combinational in the request cycle
//   h_rvalid_o/h_err_o         per-host response valid / error (qualified by rvalid)
//   h_rdata_o                  shared read data, valid for the host with rvalid
//   ram_*_o                    request forwarded to the RAM
//   ram_rvalid_i/ram_rdata_i   RAM response
// -----------------------------------------------------------------------------
module data_ram_arb #(
    parameter logic [31:0] AddrBase = 32'h0010_0000,
    parameter logic [31:0] AddrMask = 32'h0000_01FF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       h_req_i,
    input  logic [1:0]       h_we_i,
    input  logic [1:0][3:0]  h_be_i,
    input  logic [1:0][31:0] h_addr_i,
    input  logic [1:0][31:0] h_wdata_i,
    output logic [1:0]       h_gnt_o,
    output logic [1:0]       h_rvalid_o,
    output logic [1:0]       h_err_o,
    output logic [31:0]      h_rdata_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [31:0]      ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic             ram_rvalid_i,
    input  logic [31:0]      ram_rdata_i
);

    logic       pending_q;  // a response is due this cycle
    logic       owner_q;    // host that owns the due response
    logic       err_q;      // due response is a locally absorbed error
    logic       last_q;     // most recently granted host

    logic [1:0] in_win;
    logic       any_gnt;
    logic       sel;        // granted host index, meaningful only with any_gnt

    assign in_win[0] = (h_addr_i[0] & ~AddrMask) == AddrBase;
    assign in_win[1] = (h_addr_i[1] & ~AddrMask) == AddrBase;

    // Round-robin: on contention the host that did not win last time is granted.
    // last_q resets to 1 so that host 0 wins the first contention.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        h_gnt_o = 2'b00;
        unique case (h_req_i)
            2'b01:   h_gnt_o = 2'b01;
            2'b10:   h_gnt_o = 2'b10;
            2'b11:   h_gnt_o = last_q ? 2'b01 : 2'b10;
            default: h_gnt_o = 2'b00;
        endcase
    end

    assign any_gnt = |h_gnt_o;
    assign sel     = h_gnt_o[1];

    // Forward the granted host's request; out-of-window requests never reach
    // the RAM. Data outputs idle at zero when nothing is granted.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (any_gnt) begin
            ram_req_o   = in_win[sel];
            ram_we_o    = h_we_i[sel];
            ram_be_o    = h_be_i[sel];
            ram_addr_o  = h_addr_i[sel];
            ram_wdata_o = h_wdata_i[sel];
        end
    end

    // Response tracking: every grant yields exactly one response next cycle.
    // Reset drops any outstanding response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            pending_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= sel;
                err_q   <= ~in_win[sel];
                last_q  <= sel;
            end
        end
    end

    assign h_rvalid_o[0] = pending_q & ~owner_q;
    assign h_rvalid_o[1] = pending_q &  owner_q;
    assign h_err_o       = h_rvalid_o & {2{err_q}};
    assign h_rdata_o     = err_q ? 32'h0 : ram_rdata_i;

    // The RAM must answer exactly the forwarded requests, one cycle later.
    ram_rvalid_chk: assert property (
        @(posedge clk_i) disable iff (rst_i)
        ram_rvalid_i == (pending_q && !err_q)
    ) else $fatal(1, "data_ram_arb: ram_rvalid_i disagrees with outstanding response");

endmodule

// File: tb/tb_data_ram_arb.sv
module tb_data_ram_arb;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int unsigned WIN_BYTES = 512;

    logic             clk_i;
    logic             rst_i;
    logic [1:0]       h_req_i;
    logic [1:0]       h_we_i;
    logic [1:0][3:0]  h_be_i;
    logic [1:0][31:0] h_addr_i;
    logic [1:0][31:0] h_wdata_i;
    logic [1:0]       h_gnt_o;
    logic [1:0]       h_rvalid_o;
    logic [1:0]       h_err_o;
    logic [31:0]      h_rdata_o;
    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [31:0]      ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic             ram_rvalid_i;
    logic [31:0]      ram_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    data_ram_arb dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .h_req_i     (h_req_i),
        .h_we_i      (h_we_i),
        .h_be_i      (h_be_i),
        .h_addr_i    (h_addr_i),
        .h_wdata_i   (h_wdata_i),
        .h_gnt_o     (h_gnt_o),
        .h_rvalid_o  (h_rvalid_o),
        .h_err_o     (h_err_o),
        .h_rdata_o   (h_rdata_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rvalid_i(ram_rvalid_i),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single-port RAM, 128 words, 1-cycle read latency, byte-enabled writes.
    logic [31:0] ram_mem [128];

    initial begin
        for (int i = 0; i < 128; i++) ram_mem[i] = 32'h0;
    end

    // NOTE: the storage array has no reset; only the valid flag is reset, as a
    // real RAM macro keeps its contents and merely restarts its handshake.
    always @(posedge clk_i) begin
        if (ram_req_o) begin
            ram_rdata_i <= ram_mem[ram_addr_o[8:2]];
            if (ram_we_o)
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o[8:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ram_rvalid_i <= 1'b0;
        else       ram_rvalid_i <= ram_req_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we,
                         input logic [3:0] be0, input logic [3:0] be1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        h_req_i      = req;
        h_we_i       = we;
        h_be_i[0]    = be0;
        h_be_i[1]    = be1;
        h_addr_i[0]  = a0;
        h_addr_i[1]  = a1;
        h_wdata_i[0] = d0;
        h_wdata_i[1] = d1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_i = 1'b1;
        idle();
        @(negedge clk_i);
        check("reset_rvalid", {30'h0, h_rvalid_o}, 32'h0);
        check("reset_err", {30'h0, h_err_o}, 32'h0);
        next_cycle();
        rst_i = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic        ram_req;
        logic [1:0]  rvalid;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic        chk_rd;
    } vec_t;

    vec_t vecs [12];

    // ---------------- reference model ----------------
    logic [31:0] m_mem [128];
    logic        m_last;
    logic        m_pend;
    logic        m_owner;
    logic        m_err;
    logic        m_rd;
    logic [31:0] m_rdata;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + WIN_BYTES);
    endfunction

    // Called with this cycle's inputs applied: checks outputs at the negedge,
    // then advances the model by one cycle.
    task automatic model_cycle();
        int          w;
        logic        any;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        int          idx;
        @(negedge clk_i);
        any = (h_req_i != 2'b00);
        if (h_req_i == 2'b11) w = m_last ? 0 : 1;
        else                  w = h_req_i[1] ? 1 : 0;
        e_gnt = any ? (w == 1 ? 2'b10 : 2'b01) : 2'b00;
        check("rnd_gnt", {30'h0, h_gnt_o}, {30'h0, e_gnt});
        check("rnd_ram_req", {31'h0, ram_req_o}, {31'h0, any && in_window(h_addr_i[w])});
        if (any) begin
            check("rnd_ram_addr", ram_addr_o, h_addr_i[w]);
            check("rnd_ram_we", {31'h0, ram_we_o}, {31'h0, h_we_i[w]});
            check("rnd_ram_be", {28'h0, ram_be_o}, {28'h0, h_be_i[w]});
            check("rnd_ram_wdata", ram_wdata_o, h_wdata_i[w]);
        end else begin
            check("rnd_ram_addr_idle", ram_addr_o, 32'h0);
            check("rnd_ram_wdata_idle", ram_wdata_o, 32'h0);
        end
        e_rv = m_pend ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check("rnd_rvalid", {30'h0, h_rvalid_o}, {30'h0, e_rv});
        check("rnd_err", {30'h0, h_err_o}, {30'h0, m_err ? e_rv : 2'b00});
        if (m_pend && (m_err || m_rd))
            check("rnd_rdata", h_rdata_o, m_err ? 32'h0 : m_rdata);

        m_pend = any;
        if (any) begin
            m_owner = (w == 1);
            m_err   = !in_window(h_addr_i[w]);
            m_rd    = !h_we_i[w];
            m_last  = (w == 1);
            if (!m_err) begin
                idx     = int'((h_addr_i[w] - BASE) / 4);
                m_rdata = m_mem[idx];
                if (h_we_i[w])
                    for (int b = 0; b < 4; b++)
                        if (h_be_i[w][b]) m_mem[idx][8*b +: 8] = h_wdata_i[w][8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(4, 0))
            0, 1:    return BASE | {23'h0, r[8:0]};
            2:       return BASE + WIN_BYTES + {30'h0, r[1:0]};
            3:       return BASE - 32'd4 + {30'h0, r[1:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{2'b01, 2'b01, 4'hF, 4'h0, 32'h0010_0004, 32'h0, 32'hDEAD_BEEF, 32'h0,
                     2'b01, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
        vecs[1]  = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h0010_0004, 32'h0, 32'h0, 32'h0,
                     2'b01, 1'b1, 2'b01, 2'b00, 32'h0, 1'b0};
        vecs[2]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'b00, 1'b0, 2'b01, 2'b00, 32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{2'b10, 2'b00, 4'h0, 4'hF, 32'h0, 32'h0020_0000, 32'h0, 32'h0,
                     2'b10, 1'b0, 2'b00, 2'b00, 32'h0, 1'b0};
        vecs[4]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'b00, 1'b0, 2'b10, 2'b10, 32'h0, 1'b1};
        vecs[5]  = '{2'b01, 2'b01, 4'hF, 4'h0, 32'h0010_0008, 32'h0, 32'h1122_3344, 32'h0,
                     2'b01, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
        vecs[6]  = '{2'b01, 2'b01, 4'b0010, 4'h0, 32'h0010_0008, 32'h0, 32'h0000_AB00, 32'h0,
                     2'b01, 1'b1, 2'b01, 2'b00, 32'h0, 1'b0};
        vecs[7]  = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h0010_0008, 32'h0, 32'h0, 32'h0,
                     2'b01, 1'b1, 2'b01, 2'b00, 32'h0, 1'b0};
        vecs[8]  = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'b00, 1'b0, 2'b01, 2'b00, 32'h1122_AB44, 1'b1};
        vecs[9]  = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h0010_0004, 32'h0, 32'h0, 32'h0,
                     2'b01, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0};
        vecs[10] = '{2'b01, 2'b00, 4'hF, 4'h0, 32'h0020_0004, 32'h0, 32'h0, 32'h0,
                     2'b01, 1'b0, 2'b01, 2'b00, 32'hDEAD_BEEF, 1'b1};
        vecs[11] = '{2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'b00, 1'b0, 2'b01, 2'b01, 32'h0, 1'b1};

        rst_i = 1'b1;
        idle();
        @(negedge clk_i);
        check("por_rvalid", {30'h0, h_rvalid_o}, 32'h0);
        check("por_err", {30'h0, h_err_o}, 32'h0);
        check("por_ram_req", {31'h0, ram_req_o}, 32'h0);
        next_cycle();
        rst_i = 1'b0;

        // Tests 1, 3, 4, 6 as table rows starting from reset state.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            drive(vecs[i].req, vecs[i].we, vecs[i].be0, vecs[i].be1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk_i);
            check($sformatf("vec%0d_gnt", i), {30'h0, h_gnt_o}, {30'h0, vecs[i].gnt});
            check($sformatf("vec%0d_ram_req", i), {31'h0, ram_req_o}, {31'h0, vecs[i].ram_req});
            check($sformatf("vec%0d_ram_addr", i), ram_addr_o,
                  vecs[i].gnt[1] ? vecs[i].a1 : (vecs[i].gnt[0] ? vecs[i].a0 : 32'h0));
            check($sformatf("vec%0d_rvalid", i), {30'h0, h_rvalid_o}, {30'h0, vecs[i].rvalid});
            check($sformatf("vec%0d_err", i), {30'h0, h_err_o}, {30'h0, vecs[i].err});
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), h_rdata_o, vecs[i].rdata);
        end

        // Test 2: continuous contention from reset alternates 0,1,0,1,0,1.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            if (i < 6) drive(2'b11, 2'b00, 4'hF, 4'hF, 32'h0010_0010, 32'h0010_0014, 32'h0, 32'h0);
            else       idle();
            @(negedge clk_i);
            if (i < 6)
                check($sformatf("rr%0d_gnt", i), {30'h0, h_gnt_o}, (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr%0d_rvalid", i), {30'h0, h_rvalid_o},
                  (i == 0) ? 32'h0 : ((i % 2 == 1) ? 32'h1 : 32'h2));
        end

        // Test 5: reset right after a grant drops the response; host 0 wins after.
        next_cycle();
        drive(2'b01, 2'b00, 4'hF, 4'h0, 32'h0010_0020, 32'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("rst_pre_gnt", {30'h0, h_gnt_o}, 32'h1);
        next_cycle();
        rst_i = 1'b1;
        idle();
        @(negedge clk_i);
        check("rst_drop_rvalid0", {30'h0, h_rvalid_o}, 32'h0);
        next_cycle();
        @(negedge clk_i);
        check("rst_drop_rvalid1", {30'h0, h_rvalid_o}, 32'h0);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_release_rvalid", {30'h0, h_rvalid_o}, 32'h0);
        next_cycle();
        drive(2'b11, 2'b00, 4'hF, 4'hF, 32'h0010_0010, 32'h0010_0014, 32'h0, 32'h0);
        @(negedge clk_i);
        check("rst_first_contention", {30'h0, h_gnt_o}, 32'h1);
        next_cycle();
        idle();
        @(negedge clk_i);
        check("rst_after_rvalid", {30'h0, h_rvalid_o}, 32'h1);

        // Randomized phase against the reference model.
        do_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
        m_mem[1] = 32'hDEAD_BEEF;
        m_mem[2] = 32'h1122_AB44;
        m_last  = 1'b1;
        m_pend  = 1'b0;
        m_owner = 1'b0;
        m_err   = 1'b0;
        m_rd    = 1'b0;
        m_rdata = 32'h0;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            drive(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                  4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                  rand_addr(), rand_addr(), $urandom, $urandom);
            model_cycle();
        end
        next_cycle();
        idle();
        model_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
